t_ff_mod_counter: RTL and testbench
===================================

Name: t_ff_mod_counter

Overview:
- Synchronous modulo up/down counter built from edge-triggered toggle cells.
- It is the clocked successor to the level-sensitive T latch stage. Each count bit is a T flip-flop whose toggle input is derived from the lower bits.
- It produces a bit vector plus a cascade terminal-count signal and a wrap pulse. These feed the display/decoder stages downstream.

Parameters:
- WIDTH, 4, number of count bits.
- MOD, 10, count modulus; Q counts 0..MOD-1. Legal range: 2 <= MOD <= 2**WIDTH. Out of range is an elaboration error.

Ports:
- clk  in  1  rising-edge clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; one step per clk edge while high.
- up_dn  in  1  direction; 1 = up, 0 = down.
- load  in  1  synchronous parallel load.
- D  in  WIDTH  load value.
- Q  out  WIDTH  current count.
- Qn  out  WIDTH  bitwise complement of Q.
- tc  out  1  terminal count, combinational, for cascading.
- wrap  out  1  registered one-cycle pulse after a wrap step.

Behaviour:
- Reset: on a clk edge with rst=1, Q=0, Qn=all ones, wrap=0. Reset overrides load and en.
- Reset mid-count or with load=1: reset wins. The count restarts from 0 on the next enabled edge.
- Priority per edge: rst > load > en > hold.
- Load, D < MOD: Q <= D.
- Load, D >= MOD: Q <= MOD-1 (clamp).
- Load always forces wrap <= 0, regardless of en.
- Count up (en=1, up_dn=1): Q <= Q+1. If Q == MOD-1, Q <= 0 instead.
- Count down (en=1, up_dn=0): Q <= Q-1. If Q == 0, Q <= MOD-1 instead.
- Hold (en=0, load=0): Q unchanged, wrap <= 0.
- Toggle vector: T[i] = Q_next[i] XOR Q[i]. Each bit is stored in a t_ff_cell that toggles when T[i]=1 on the edge.
  - Pure binary up with MOD = 2**WIDTH: T[i] = en AND all lower bits 1.
  - Down: T[i] = en AND all lower bits 0.
  - Modulo wrap overrides these patterns.
- tc = en AND ((up_dn AND Q==MOD-1) OR (!up_dn AND Q==0)).
  - Purely combinational, same cycle, no registered delay.
  - Intended as the next stage's en.
- wrap: registered. Asserted for exactly one cycle following any edge on which Q wrapped (tc was 1 and no load/rst). Otherwise 0.
- Latency: Q, Qn and wrap update 1 clk after the qualifying edge.
- Direction change: may toggle on any cycle. Takes effect on that edge with no dead cycle. tc re-evaluates immediately.
- Q is never outside 0..MOD-1 after reset.
- No latches: all state is in clk-edge flops. No asynchronous paths.

Decomposition:
- Shared header counter_defs: localparams DIR_UP=1, DIR_DOWN=0 and a clog2 helper for deriving WIDTH from MOD. Reused by sibling counters.
- Sub-module t_ff_cell (1 bit) with ports clk, rst, ld, d, T, Q, Qn.
  - Synchronous reset to 0.
  - ld loads d.
  - Otherwise Q <= Q XOR T.
  - This is the flip-flop counterpart of the T latch.
- The top level instantiates WIDTH cells via generate. It holds the toggle-vector logic, clamp, tc and wrap register.

Test Plan:
- Reset: drive rst=1 for 2 cycles with en=1, load=1, D=7. Required: Q=0, Qn=4'b1111, wrap=0 throughout and on the first edge after release.
- Up wrap (WIDTH=4, MOD=10): en=1, up_dn=1 for 12 cycles from 0. Required: Q = 1..9, 0, 1, 2. tc=1 only while Q=9. wrap=1 exactly in the cycle Q shows 0.
- Down wrap: load D=1, then en=1, up_dn=0 for 3 cycles. Required: Q = 0, 9, 8. tc=1 while Q=0. wrap pulses once with Q=9.
- Load clamp and priority: load=1, D=13, en=1. Required: Q=9, wrap=0. Then en=0 for 3 cycles: Q holds 9, tc=0.
- Mid-count direction flip: from Q=4 count up 2 edges (Q=6), then flip up_dn=0 for 3 edges. Required: Q = 5, 4, 3, no wrap pulse.
- Full binary (WIDTH=3, MOD=8): 16 up edges. Required: Q cycles 0..7 twice. Check each bit's toggle matches T[i] = AND of lower bits. wrap pulses exactly twice.

Source files
------------

// File: rtl/t_ff_mod_counter_pkg.sv
// Shared counter definitions: direction encodings and a ceiling-log2 helper
// used to check, or derive, a counter width from its modulus.
package t_ff_mod_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Number of bits needed to hold the values 0..value-1.
  function automatic int clog2_f(input int value);
    int bits_v;
    bits_v = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      bits_v = bits_v + 1;
    end
    return bits_v;
  endfunction

endpackage

// File: rtl/t_ff_mod_counter_if.sv
// Control and status bundle of the modulo counter; clk and rst stay outside.
interface t_ff_mod_counter_if #(
  parameter int WIDTH = 4
) ();

  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qn;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up_dn, load, D,
    input  Q, Qn, tc, wrap
  );

  modport slave (
    input  en, up_dn, load, D,
    output Q, Qn, tc, wrap
  );

endinterface

// File: rtl/t_ff_mod_counter_cell.sv
// One edge-triggered toggle cell: reset clears, ld loads d, otherwise the
// stored bit flips whenever T is high on the clock edge.
module t_ff_cell (
  input  logic clk,
  input  logic rst,
  input  logic ld,
  input  logic d,
  input  logic T,
  output logic Q,
  output logic Qn
);

  logic q_r;
  logic qn_r;

  // Bit storage with its complement kept as a second flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r  <= 1'b0;
      qn_r <= 1'b1;
    end else if (ld) begin
      q_r  <= d;
      qn_r <= ~d;
    end else begin
      q_r  <= q_r ^ T;
      qn_r <= ~(q_r ^ T);
    end
  end

  assign Q  = q_r;
  assign Qn = qn_r;

endmodule

// File: rtl/t_ff_mod_counter.sv
// Modulo up/down counter built from toggle cells; provides a combinational
// cascade terminal count and a registered one-cycle wrap pulse.
module t_ff_mod_counter
  import t_ff_mod_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  t_ff_mod_counter_if.slave    bus
);

  if ((MOD < 2) || (clog2_f(MOD) > WIDTH)) begin : g_bad_mod
    $error("t_ff_mod_counter: MOD must satisfy 2 <= MOD <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MOD_MAX = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] qn_s;
  logic [WIDTH-1:0] q_next_s;
  logic [WIDTH-1:0] t_s;
  logic [WIDTH-1:0] load_val_s;
  logic             at_max_s;
  logic             at_zero_s;
  logic             tc_s;
  logic             wrap_r;

  // Next count, clamped load value, terminal count and toggle vector.
  always_comb begin
    at_max_s   = (q_s == MOD_MAX);
    at_zero_s  = (q_s == ZERO);
    tc_s       = bus.en & (((bus.up_dn == DIR_UP) & at_max_s) |
                           ((bus.up_dn == DIR_DOWN) & at_zero_s));
    load_val_s = (bus.D > MOD_MAX) ? MOD_MAX : bus.D;
    q_next_s   = q_s;
    if (bus.load) begin
      q_next_s = load_val_s;
    end else if (bus.en) begin
      if (bus.up_dn == DIR_UP) begin
        q_next_s = at_max_s ? ZERO : (q_s + ONE);
      end else begin
        q_next_s = at_zero_s ? MOD_MAX : (q_s - ONE);
      end
    end else begin
      q_next_s = q_s;
    end
    // The cells take the load path themselves, so T only matters when counting.
    t_s = q_next_s ^ q_s;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .ld  (bus.load),
      .d   (load_val_s[i]),
      .T   (t_s[i]),
      .Q   (q_s[i]),
      .Qn  (qn_s[i])
    );
  end

  // Wrap pulse: set after an edge that stepped across the modulus boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_r <= 1'b0;
    end else if (bus.load) begin
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= tc_s;
    end
  end

  assign bus.Q    = q_s;
  assign bus.Qn   = qn_s;
  assign bus.tc   = tc_s;
  assign bus.wrap = wrap_r;

endmodule

// File: tb/tb_t_ff_mod_counter.sv
// Bench for t_ff_mod_counter: a decimal (4-bit, mod 10) and a full binary
// (3-bit, mod 8) instance, checked against an integer model every cycle.
module tb_t_ff_mod_counter;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  bit   chk_on;
  int   ma;
  int   mb;
  bit   wa;
  bit   wb;

  t_ff_mod_counter_if #(.WIDTH(4)) ifa ();
  t_ff_mod_counter_if #(.WIDTH(3)) ifb ();

  t_ff_mod_counter #(.WIDTH(4), .MOD(10)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  t_ff_mod_counter #(.WIDTH(3), .MOD(8))  dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_count(input int m, input int md, input bit r,
                                    input bit ld, input int d, input bit e,
                                    input bit up);
    if (r) return 0;
    if (ld) return (d >= md) ? md - 1 : d;
    if (e) return up ? (m + 1) % md : (m + md - 1) % md;
    return m;
  endfunction

  function automatic bit tc_of(input int m, input int md, input bit e, input bit up);
    return e && ((up && m == md - 1) || (!up && m == 0));
  endfunction

  // Reference model: plain modular arithmetic advanced on each rising edge.
  always @(posedge clk) begin
    if (rst) chk_on <= 1'b1;
    ma <= next_count(ma, 10, rst, ifa.load, int'(ifa.D), ifa.en, ifa.up_dn);
    mb <= next_count(mb, 8,  rst, ifb.load, int'(ifb.D), ifb.en, ifb.up_dn);
    wa <= !rst && !ifa.load && tc_of(ma, 10, ifa.en, ifa.up_dn);
    wb <= !rst && !ifb.load && tc_of(mb, 8,  ifb.en, ifb.up_dn);
  end

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("a_q",    ifa.Q,    ma);
      chk("a_qn",   ifa.Qn,   ma ^ 15);
      chk("a_tc",   ifa.tc,   int'(tc_of(ma, 10, ifa.en, ifa.up_dn)));
      chk("a_wrap", ifa.wrap, int'(wa));
      chk("b_q",    ifb.Q,    mb);
      chk("b_qn",   ifb.Qn,   mb ^ 7);
      chk("b_tc",   ifb.tc,   int'(tc_of(mb, 8, ifb.en, ifb.up_dn)));
      chk("b_wrap", ifb.wrap, int'(wb));
    end
  end

  task automatic edge_a(input logic r, input logic ld, input logic e,
                        input logic u, input logic [3:0] d);
    rst = r; ifa.load = ld; ifa.en = e; ifa.up_dn = u; ifa.D = d;
    @(posedge clk);
    #1;
  endtask

  task automatic edge_b(input logic ld, input logic e, input logic u,
                        input logic [2:0] d);
    rst = 1'b0; ifb.load = ld; ifb.en = e; ifb.up_dn = u; ifb.D = d;
    @(posedge clk);
    #1;
  endtask

  int exp_up [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp_dn [3]  = '{0, 9, 8};

  initial begin
    int wrap_cnt;
    logic [2:0] prev_q;
    logic [2:0] exp_t;
    n_tests = 0; n_fail = 0; chk_on = 1'b0;
    ma = 0; mb = 0; wa = 1'b0; wb = 1'b0;
    ifb.en = 1'b0; ifb.load = 1'b0; ifb.up_dn = 1'b1; ifb.D = 3'd0;

    // Reset overrides load and enable.
    for (int i = 0; i < 2; i++) begin
      edge_a(1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
      chk("rst_q", ifa.Q, 0);
      chk("rst_qn", ifa.Qn, 15);
      chk("rst_wrap", ifa.wrap, 0);
    end
    edge_a(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    chk("rel_q", ifa.Q, 0);
    chk("rel_wrap", ifa.wrap, 0);

    // Up count through the modulus.
    for (int i = 0; i < 12; i++) begin
      edge_a(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
      chk("up_q", ifa.Q, exp_up[i]);
      chk("up_tc", ifa.tc, (exp_up[i] == 9) ? 1 : 0);
      chk("up_wrap", ifa.wrap, (i == 9) ? 1 : 0);
    end

    // Down count through zero.
    edge_a(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    chk("ld1_q", ifa.Q, 1);
    for (int i = 0; i < 3; i++) begin
      edge_a(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      chk("dn_q", ifa.Q, exp_dn[i]);
      chk("dn_tc", ifa.tc, (i == 0) ? 1 : 0);
      chk("dn_wrap", ifa.wrap, (i == 1) ? 1 : 0);
    end

    // Load clamps and beats enable, then hold.
    edge_a(1'b0, 1'b1, 1'b1, 1'b0, 4'd13);
    chk("clamp_q", ifa.Q, 9);
    chk("clamp_wrap", ifa.wrap, 0);
    for (int i = 0; i < 3; i++) begin
      edge_a(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      chk("hold_q", ifa.Q, 9);
      chk("hold_tc", ifa.tc, 0);
    end

    // Direction flip mid-count.
    edge_a(1'b0, 1'b1, 1'b0, 1'b1, 4'd4);
    chk("ld4_q", ifa.Q, 4);
    edge_a(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    edge_a(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    chk("flip_up_q", ifa.Q, 6);
    for (int i = 0; i < 3; i++) begin
      edge_a(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      chk("flip_dn_q", ifa.Q, 5 - i);
      chk("flip_wrap", ifa.wrap, 0);
    end

    // Reset mid-count with load asserted, then restart from zero.
    edge_a(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
    chk("midrst_q", ifa.Q, 0);
    edge_a(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    chk("restart_q", ifa.Q, 1);
    edge_a(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);

    // Full binary instance: 16 up edges, toggle pattern and wrap count.
    wrap_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      prev_q = ifb.Q;
      edge_b(1'b0, 1'b1, 1'b1, 3'd0);
      for (int k = 0; k < 3; k++) begin
        exp_t[k] = 1'b1;
        for (int j = 0; j < k; j++) begin
          if (prev_q[j] == 1'b0) exp_t[k] = 1'b0;
        end
      end
      chk("bin_toggle", prev_q ^ ifb.Q, int'(exp_t));
      chk("bin_q", ifb.Q, (i + 1) % 8);
      if (ifb.wrap === 1'b1) wrap_cnt++;
    end
    chk("bin_wrap_count", wrap_cnt, 2);
    edge_b(1'b0, 1'b0, 1'b1, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
